mult_scheduler: RTL
===================

# mult_scheduler

Round-robin scheduler that shares one sequential multiplier between `REQ` requesters. It accepts operand pairs, launches the multiplier with a one-cycle `start` pulse, waits for `finished`, and returns the product to the granted requester with a one-cycle `done` pulse. It sits between client datapaths and the single `Multiplier` instance in the ALU.

## Interface
- `n`, 8, operand width; product width is `2*n`
- `REQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 64, watchdog limit in cycles (used only with `MULT_SCHED_TIMEOUT_EN`)

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `req`  in  REQ  per-requester level request
- `a_in`  in  REQ*n  operand A; requester i occupies bits [i*n +: n]
- `b_in`  in  REQ*n  operand B, same packing
- `grant`  out  REQ  one-hot, one-cycle pulse when operands are accepted
- `done`  out  REQ  one-hot, one-cycle pulse when `result` is valid for that requester
- `result`  out  2n  product, held until the next DONE
- `busy`  out  1  high in every state except IDLE
- `error`  out  1  pulses with `done` on timeout; tied 0 when the feature is compiled out
- `mul_start`  out  1  start pulse to the multiplier
- `mul_a`, `mul_b`  out  n  latched operands to the multiplier
- `mul_product`  in  2n  multiplier product
- `mul_finished`  in  1  multiplier completion flag

## Operation
- FSM states: IDLE, LAUNCH, WAIT, DONE.
- IDLE: if `req` is nonzero, pick the winner by round-robin, searching from `last+1` upward with wrap. Latch the index and its A/B into `mul_a`/`mul_b`, then go to LAUNCH. If `req` is zero, stay in IDLE.
- LAUNCH: `grant[idx]`=1 and `mul_start`=1 for exactly this cycle. `mul_finished` is ignored in this cycle, because a stale flag may remain from the previous operation. Go to WAIT.
- WAIT: on `mul_finished`=1, register `mul_product` into `result` and go to DONE.
- DONE: `done[idx]`=1 for one cycle, then `last`←idx and go to IDLE.
- Operands are captured once at the IDLE→LAUNCH edge. Later changes on `a_in`/`b_in` have no effect.
- If `req[i]` is still high in the IDLE cycle after `done[i]`, it counts as a new request. Round-robin gives every other pending requester priority first.
- A deasserted `req` during LAUNCH, WAIT or DONE does not cancel the operation.
- Simultaneous requests: exactly one grant is issued. The others wait, with no loss and no starvation; maximum wait is REQ−1 operations.

## Timing
- Reset value of all outputs is 0, including `mul_a`, `mul_b` and `result`. `last` resets to REQ−1, so requester 0 wins first.
- Reset asserted mid-operation: the FSM goes to IDLE immediately (asynchronously) and the operation is discarded with no `done`. The multiplier is reset by its own port.
- Latency, with `req` seen in IDLE at cycle 0:
  - `grant` and `mul_start` are high in cycle 1.
  - `mul_finished` is first sampled in cycle 2.
  - If it is seen in cycle m, `done` and `result` are valid in cycle m+1, and the FSM is back in IDLE in cycle m+2.
- Minimum occupancy is 4 cycles per operation (finished in the first WAIT cycle).
- All outputs are registered and decoded from state.

## Configuration
- `MULT_SCHED_TIMEOUT_EN` defined: a counter clears on entry to WAIT and increments each WAIT cycle. When it reaches `TIMEOUT` without `mul_finished`, the FSM goes to DONE with `error`=1 and `result`=0, and `done[idx]` still pulses. If `finished` and the limit coincide, `finished` wins and `error`=0.
- Not defined: no counter; WAIT waits indefinitely; `error` is constant 0.

## Structure
- Shared package `mult_sched_pkg` holds:
  - state encodings: IDLE=2'd0, LAUNCH=2'd1, WAIT=2'd2, DONE=2'd3
  - default widths
  - the timeout counter width, `$clog2(TIMEOUT+1)`
- One sub-module, `rr_picker`: a combinational round-robin priority encoder taking (`req`, `last`) and producing (`valid`, `idx`). It is reusable by other shared-resource schedulers.

## Test plan
All scenarios use a stub multiplier whose `finished` arrives 3 cycles after `start`, unless noted.
- Single requester: `req`=0001, A=13, B=9 → `grant`=0001 in cycle 1, `mul_start` in cycle 1, `done`=0001 with `result`=117 after `finished`, `busy` back to 0.
- All four requesting at once, A=i+1, B=2 → grants in order 0,1,2,3 and results 2,4,6,8. Then hold `req`=1001 → next grants go 0,3,0,3.
- Stale `finished`: hold `mul_finished`=1 during LAUNCH → it is not accepted, and `done` appears only after a fresh `finished` in WAIT.
- Reset low during WAIT → all outputs are 0 in the same cycle and no `done` is issued. After release, `req`=0010 is granted first (pointer reset).
- With `MULT_SCHED_TIMEOUT_EN`, `TIMEOUT`=8, and the stub never asserting `finished` → `done` and `error` pulse together 8 WAIT cycles after entry, with `result`=0.
- Operands changed right after `grant` (A 255→0) → `result`=255×B, confirming capture at grant.

Source files
------------

// File: rtl/mult_sched_pkg.sv
// Shared definitions for the multiplier scheduler: FSM encodings, default widths
// and the watchdog counter width helper.
package mult_sched_pkg;

    localparam int N_DEF       = 8;
    localparam int REQ_DEF     = 4;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int TO_W_DEF = $clog2(TIMEOUT_DEF + 1);

    function automatic int timeout_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mult_scheduler_rr_picker.sv
// Combinational round-robin priority encoder: searches req from last+1 upward
// with wrap and returns the first set index.
module rr_picker #(
    parameter int REQ = 4,
    parameter int IW  = 2
) (
    input  logic [REQ-1:0] req,
    input  logic [IW-1:0]  last,
    output logic           valid,
    output logic [IW-1:0]  idx
);

    logic [IW-1:0]  cand_s [REQ];
    logic [REQ-1:0] hit_s;

    for (genvar g = 0; g < REQ; g++) begin : g_cand
        assign cand_s[g] = IW'((int'(last) + g + 1) % REQ);
        assign hit_s[g]  = req[cand_s[g]];
    end

    // Priority select: walking down means the nearest candidate after last wins.
    always_comb begin
        valid = |hit_s;
        idx   = {IW{1'b0}};
        for (int k = REQ - 1; k >= 0; k--) begin
            idx = hit_s[k] ? cand_s[k] : idx;
        end
    end

endmodule

// File: rtl/mult_scheduler.sv
// Round-robin scheduler sharing one sequential multiplier between REQ clients.
// Optional watchdog on the WAIT state is enabled by defining MULT_SCHED_TIMEOUT_EN.
module mult_scheduler
    import mult_sched_pkg::*;
#(
    parameter int n       = N_DEF,
    parameter int REQ     = REQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REQ-1:0]   req,
    input  logic [REQ*n-1:0] a_in,
    input  logic [REQ*n-1:0] b_in,
    output logic [REQ-1:0]   grant,
    output logic [REQ-1:0]   done,
    output logic [2*n-1:0]   result,
    output logic             busy,
    output logic             error,
    output logic             mul_start,
    output logic [n-1:0]     mul_a,
    output logic [n-1:0]     mul_b,
    input  logic [2*n-1:0]   mul_product,
    input  logic             mul_finished
);

    localparam int IW = $clog2(REQ);

    state_e          state_r, state_nx_s;
    logic [IW-1:0]   idx_r, idx_nx_s, last_r;
    logic            pick_valid_s;
    logic [IW-1:0]   pick_idx_s;
    logic            timeout_s;
    logic            capture_s, finish_s;
    logic [REQ-1:0]  grant_nx_s, done_nx_s;
    logic            mul_start_nx_s, busy_nx_s;
    logic [n-1:0]    mul_a_nx_s, mul_b_nx_s;
    logic [2*n-1:0]  result_nx_s;

    function automatic logic [REQ-1:0] onehot(input logic [IW-1:0] i);
        return {{(REQ-1){1'b0}}, 1'b1} << i;
    endfunction

    rr_picker #(.REQ(REQ), .IW(IW)) u_picker (
        .req   (req),
        .last  (last_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

`ifdef MULT_SCHED_TIMEOUT_EN
    localparam int TO_W = timeout_width(TIMEOUT);
    logic [TO_W-1:0] cnt_r;
    logic            error_nx_s;

    assign timeout_s = (state_r == WAIT) && (cnt_r == TO_W'(TIMEOUT - 1));

    // Watchdog counter: zero outside WAIT, so it is clear on every entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r <= {TO_W{1'b0}};
        end else if (state_r == WAIT) begin
            cnt_r <= cnt_r + TO_W'(1);
        end else begin
            cnt_r <= {TO_W{1'b0}};
        end
    end

    // Error accompanies done only when the watchdog, not finished, ended WAIT.
    assign error_nx_s = finish_s && !mul_finished;

    // Registered error flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            error <= 1'b0;
        end else begin
            error <= error_nx_s;
        end
    end
`else
    assign timeout_s = 1'b0;
    assign error     = 1'b0;
`endif

    // State register plus the granted index and round-robin pointer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            idx_r   <= {IW{1'b0}};
            last_r  <= IW'(REQ - 1);
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            last_r  <= (state_r == DONE) ? idx_r : last_r;
        end
    end

    // Next-state logic; finished is only honoured in WAIT so a stale flag is ignored.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_nx_s = LAUNCH;
                    idx_nx_s   = pick_idx_s;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            LAUNCH: state_nx_s = WAIT;
            WAIT: begin
                if (mul_finished || timeout_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = WAIT;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        capture_s      = (state_r == IDLE) && pick_valid_s;
        finish_s       = (state_r == WAIT) && (state_nx_s == DONE);
        grant_nx_s     = (state_nx_s == LAUNCH) ? onehot(idx_nx_s) : {REQ{1'b0}};
        done_nx_s      = (state_nx_s == DONE) ? onehot(idx_r) : {REQ{1'b0}};
        mul_start_nx_s = (state_nx_s == LAUNCH);
        busy_nx_s      = (state_nx_s != IDLE);
        mul_a_nx_s     = capture_s ? a_in[int'(pick_idx_s)*n +: n] : mul_a;
        mul_b_nx_s     = capture_s ? b_in[int'(pick_idx_s)*n +: n] : mul_b;
        if (finish_s) begin
            result_nx_s = mul_finished ? mul_product : {(2*n){1'b0}};
        end else begin
            result_nx_s = result;
        end
    end

    // Output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant     <= {REQ{1'b0}};
            done      <= {REQ{1'b0}};
            result    <= {(2*n){1'b0}};
            busy      <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= {n{1'b0}};
            mul_b     <= {n{1'b0}};
        end else begin
            grant     <= grant_nx_s;
            done      <= done_nx_s;
            result    <= result_nx_s;
            busy      <= busy_nx_s;
            mul_start <= mul_start_nx_s;
            mul_a     <= mul_a_nx_s;
            mul_b     <= mul_b_nx_s;
        end
    end

endmodule
